// File: rtl/i2c_req_arbiter_if.sv
// Signal bundle between four requesters, the arbiter and a single I2C master engine.
// Per-requester fields are packed [requester][field] so requester i owns bits [W*i+W-1:W*i].
interface i2c_req_arbiter_if;
  logic [3:0]      req;
  logic [3:0][6:0] req_addr;
  logic [3:0]      req_rw;
  logic [3:0][7:0] req_wdata;
  logic [3:0]      gnt;
  logic [3:0]      rsp_valid;
  logic [7:0]      rsp_rdata;
  logic            rsp_err;
  logic            m_start;
  logic [6:0]      m_addr;
  logic            m_rw;
  logic [7:0]      m_wdata;
  logic            m_busy;
  logic            m_done;
  logic            m_ack_err;
  logic [7:0]      m_rdata;

  // slave = the arbiter; master = requesters plus the I2C engine around it
  modport slave (
    input  req, req_addr, req_rw, req_wdata, m_busy, m_done, m_ack_err, m_rdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err, m_start, m_addr, m_rw, m_wdata
  );
  modport master (
    output req, req_addr, req_rw, req_wdata, m_busy, m_done, m_ack_err, m_rdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, m_start, m_addr, m_rw, m_wdata
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin 4-requester front end for one I2C master: grants, issues one transaction at a
// time, waits for completion or timeout, returns a one-cycle response and keeps statistics.
module i2c_req_arbiter #(
  parameter int TIMEOUT_CYC = 400000,
  parameter int SYS_FREQ    = 40000000
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_req_arbiter_if.slave     bus,
  output logic [15:0]          tx_count,
  output logic [7:0]           err_count
);

  if (TIMEOUT_CYC < 1 || SYS_FREQ < 1) begin : g_bad_param
    $error("i2c_req_arbiter: TIMEOUT_CYC and SYS_FREQ must be positive");
  end

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    win_q;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    win;
  logic          any;

  // Rotating search: scanning offsets high to low lets the lowest offset from ptr win.
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        win = ptr + 2'(k);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      win_q         <= '0;
      tmo_cnt       <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.m_start   <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_rw      <= 1'b0;
      bus.m_wdata   <= '0;
      tx_count      <= '0;
      err_count     <= '0;
    end else begin
      bus.m_start   <= 1'b0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: if (|bus.req) state <= ARB;
        ARB: begin
          if (any) begin
            win_q       <= win;
            bus.gnt     <= 4'b0001 << win;
            bus.m_addr  <= bus.req_addr[win];
            bus.m_rw    <= bus.req_rw[win];
            bus.m_wdata <= bus.req_wdata[win];
            state       <= ISSUE;
          end else begin
            bus.gnt <= '0;
            state   <= IDLE;
          end
        end
        ISSUE: if (!bus.m_busy) begin
          bus.m_start <= 1'b1;
          tmo_cnt     <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          // A completion in the timeout cycle still carries the master's real data.
          if (bus.m_done) begin
            bus.rsp_rdata <= bus.m_rdata;
            bus.rsp_err   <= bus.m_ack_err;
            state         <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.rsp_rdata <= 8'h00;
            bus.rsp_err   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.rsp_valid <= 4'b0001 << win_q;
          bus.gnt       <= '0;
          ptr           <= win_q + 2'd1;
          tx_count      <= tx_count + 16'd1;
          if (bus.rsp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: latency vectors from a table, directed corner sequences,
// then random traffic checked against a round-robin scoreboard.
module tb_i2c_req_arbiter;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] tx_count;
  logic [7:0]  err_count;
  int          errors = 0;
  int          checks = 0;
  int          exp_tx = 0;

  i2c_req_arbiter_if bus();

  i2c_req_arbiter #(.TIMEOUT_CYC(TMO), .SYS_FREQ(40000000)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx_count(tx_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    int         delay;   // cycles after m_start before m_done; -1 = never (timeout)
    logic [7:0] rdata;
    logic       ack;
    logic [3:0] exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic [15:0] exp_tx;
    logic [7:0] exp_errc;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_m_start"}, bus.m_start, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_m_addr"}, bus.m_addr, 0);
    chk({tag, "_m_rw"}, bus.m_rw, 0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 0);
    chk({tag, "_tx_count"}, tx_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_wdata = '0;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack_err = 1'b0; bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    chk_zero("reset");
    rst = 1'b1;
    exp_tx = 0;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lane;
    lane = idx_of(v.req);
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i] = 7'($urandom); bus.req_rw[i] = 1'($urandom); bus.req_wdata[i] = 8'($urandom);
    end
    bus.req_addr[lane] = v.addr; bus.req_rw[lane] = v.rw; bus.req_wdata[lane] = v.wdata;
    bus.req = v.req;
    tick(); chk({tag, "_gnt_edge1"}, bus.gnt, 0);
    tick();
    chk({tag, "_gnt_edge2"}, bus.gnt, v.req);
    chk({tag, "_m_addr"}, bus.m_addr, v.addr);
    chk({tag, "_m_rw"}, bus.m_rw, v.rw);
    chk({tag, "_m_wdata"}, bus.m_wdata, v.wdata);
    chk({tag, "_start_edge2"}, bus.m_start, 0);
    tick(); chk({tag, "_start_edge3"}, bus.m_start, 1);
    tick(); chk({tag, "_start_pulse"}, bus.m_start, 0);
    chk({tag, "_gnt_wait"}, bus.gnt, v.req);
    if (v.delay < 0) begin
      repeat (TMO - 2) tick();
      tick(); chk({tag, "_rsp_early"}, bus.rsp_valid, 0);
      tick();
    end else begin
      repeat (v.delay - 1) tick();
      bus.m_done = 1'b1; bus.m_rdata = v.rdata; bus.m_ack_err = v.ack;
      tick(); bus.m_done = 1'b0;
      chk({tag, "_rsp_early"}, bus.rsp_valid, 0);
      tick();
    end
    chk({tag, "_rsp_valid"}, bus.rsp_valid, v.exp_valid);
    chk({tag, "_gnt_cleared"}, bus.gnt, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_rsp_err"}, bus.rsp_err, v.exp_err);
    chk({tag, "_tx_count"}, tx_count, v.exp_tx);
    chk({tag, "_err_count"}, err_count, v.exp_errc);
    chk({tag, "_m_addr_held"}, bus.m_addr, v.addr);
    bus.req = '0;
    tick(); chk({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
  endtask

  task automatic serve_one(input logic ack, output int who);
    int n;
    logic [3:0] g;
    n = 0;
    while (bus.gnt == 4'b0 && n < 10) begin tick(); chk("serve_no_rsp_pre", bus.rsp_valid, 0); n++; end
    chk("serve_gnt_onehot", $onehot(bus.gnt), 1);
    g = bus.gnt;
    who = idx_of(g);
    n = 0;
    while (!bus.m_start && n < 10) begin tick(); n++; end
    chk("serve_start_seen", bus.m_start, 1);
    bus.m_done = 1'b1; bus.m_ack_err = ack; bus.m_rdata = 8'h00;
    tick(); bus.m_done = 1'b0;
    n = 0;
    while (bus.rsp_valid == 4'b0 && n < 10) begin tick(); n++; end
    chk("serve_rsp", bus.rsp_valid, g);
    exp_tx++;
  endtask

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    vecs[0] = '{4'b0001, 7'h50, 1'b0, 8'hA5, 10, 8'h00, 1'b0, 4'b0001, 8'h00, 1'b0, 16'd1, 8'd0};
    vecs[1] = '{4'b0100, 7'h21, 1'b1, 8'h00,  5, 8'h3C, 1'b1, 4'b0100, 8'h3C, 1'b1, 16'd2, 8'd1};
    vecs[2] = '{4'b1000, 7'h7F, 1'b0, 8'hFF, -1, 8'hEE, 1'b0, 4'b1000, 8'h00, 1'b1, 16'd3, 8'd2};
    vecs[3] = '{4'b0010, 7'h00, 1'b1, 8'h5A,  1, 8'hC3, 1'b0, 4'b0010, 8'hC3, 1'b0, 16'd4, 8'd2};
    vecs[4] = '{4'b0001, 7'h2A, 1'b1, 8'h11,  2, 8'h99, 1'b1, 4'b0001, 8'h99, 1'b1, 16'd5, 8'd3};

    idle_inputs();
    tick();
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Round robin with all four requests held.
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_addr[i] = 7'(16 + i);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve_one(1'b0, who);
      chk("rr_order", who, n % 4);
      chk("rr_addr", bus.m_addr, 7'(16 + (n % 4)));
    end
    bus.req = '0;
    tick();

    // m_busy holds the start for 20 cycles; a stray m_done in ISSUE is ignored.
    bus.m_busy = 1'b1;
    bus.req = 4'b0010; bus.req_addr[1] = 7'h33;
    tick(); tick();
    chk("busy_gnt", bus.gnt, 4'b0010);
    for (int c = 1; c <= 20; c++) begin
      bus.m_done = (c == 5);
      tick();
      chk("busy_start_held", bus.m_start, 0);
      chk("busy_no_rsp", bus.rsp_valid, 0);
    end
    bus.m_done = 1'b0;
    bus.m_busy = 1'b0;
    tick(); chk("busy_start_after_fall", bus.m_start, 1);
    repeat (3) begin tick(); chk("busy_wait_no_rsp", bus.rsp_valid, 0); end
    bus.m_done = 1'b1; bus.m_rdata = 8'h44; bus.m_ack_err = 1'b0;
    tick(); bus.m_done = 1'b0;
    tick();
    exp_tx++;
    chk("busy_rsp", bus.rsp_valid, 4'b0010);
    chk("busy_rdata", bus.rsp_rdata, 8'h44);
    chk("busy_tx", tx_count, 16'(exp_tx));
    bus.req = '0;
    tick();

    // Request withdrawn before arbitration: no grant, no start.
    bus.req = 4'b0001;
    tick(); bus.req = '0;
    tick(); chk("wd_gnt", bus.gnt, 0);
    tick(); chk("wd_start", bus.m_start, 0); chk("wd_gnt2", bus.gnt, 0);

    // m_done in IDLE is ignored.
    bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0;
    repeat (3) begin tick(); chk("idle_done_no_rsp", bus.rsp_valid, 0); end
    chk("idle_done_tx", tx_count, 16'(exp_tx));

    // Asynchronous reset during WAIT abandons the transaction.
    bus.req = 4'b1000; bus.req_addr[3] = 7'h55; bus.req_wdata[3] = 8'h77;
    tick(); tick(); tick();
    chk("rstw_start", bus.m_start, 1);
    tick(); tick();
    #2 rst = 1'b0;
    #1 chk_zero("rst_wait");
    tick();
    rst = 1'b1; bus.req = '0; exp_tx = 0;
    tick();
    bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0;
    repeat (4) begin tick(); chk("rstw_no_rsp", bus.rsp_valid, 0); end

    // err_count saturates at 0xFF while tx_count keeps counting.
    do_reset();
    bus.req = 4'b0001;
    repeat (257) serve_one(1'b1, who);
    bus.req = '0;
    chk("sat_err_count", err_count, 8'hFF);
    chk("sat_tx_count", tx_count, 16'(exp_tx));
    tick();

    // Random traffic against a scoreboard of pending requests and round-robin order.
    do_reset();
    begin
      bit         pend[4];
      logic [6:0] a_m[4];
      logic       rw_m[4];
      logic [7:0] wd_m[4];
      int         waits[4];
      int         win, mptr, cd, txm, errm;
      bit         started, tmo_f;
      logic [7:0] rd;
      logic       ae, busy_prev, e_err;
      for (int i = 0; i < 4; i++) begin pend[i] = 0; waits[i] = 0; end
      win = -1; mptr = 0; cd = -1; txm = 0; errm = 0; started = 0; tmo_f = 0; rd = '0; ae = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        busy_prev = bus.m_busy;
        tick();
        bus.m_done = 1'b0;
        chk("rnd_gnt_onehot0", $onehot0(bus.gnt), 1);
        if (win < 0 && bus.gnt != 4'b0) begin
          int e;
          e = -1;
          for (int k = 3; k >= 0; k--) if (pend[(mptr + k) % 4]) e = (mptr + k) % 4;
          chk("rnd_gnt", bus.gnt, (e < 0) ? 4'b0 : 4'(1 << e));
          win = (e < 0) ? idx_of(bus.gnt) : e;
          if (win >= 0) begin
            chk("rnd_m_addr", bus.m_addr, a_m[win]);
            chk("rnd_m_rw", bus.m_rw, rw_m[win]);
            chk("rnd_m_wdata", bus.m_wdata, wd_m[win]);
            for (int i = 0; i < 4; i++) if (pend[i] && i != win) begin
              waits[i]++;
              chk("rnd_fairness", waits[i] <= 3, 1);
            end
            waits[win] = 0;
          end
        end
        if (bus.m_start) begin
          chk("rnd_start_single", (win >= 0) && !started, 1);
          chk("rnd_start_not_busy", busy_prev, 0);
          started = 1;
          tmo_f = ($urandom_range(0, 9) == 0);
          cd = $urandom_range(0, 12);
          rd = 8'($urandom); ae = 1'($urandom);
        end
        if (started && !tmo_f) begin
          if (cd == 0) begin bus.m_done = 1'b1; bus.m_rdata = rd; bus.m_ack_err = ae; end
          cd--;
        end
        if (bus.rsp_valid != 4'b0) begin
          chk("rnd_rsp_valid", bus.rsp_valid, (win >= 0 && started) ? 4'(1 << win) : 4'b0);
          e_err = tmo_f ? 1'b1 : ae;
          chk("rnd_rsp_rdata", bus.rsp_rdata, tmo_f ? 8'h00 : rd);
          chk("rnd_rsp_err", bus.rsp_err, e_err);
          chk("rnd_gnt_clear", bus.gnt, 0);
          txm++;
          if (e_err && errm < 255) errm++;
          chk("rnd_tx_count", tx_count, 16'(txm));
          chk("rnd_err_count", err_count, 8'(errm));
          if (win >= 0) begin
            pend[win] = 0; bus.req[win] = 1'b0; mptr = (win + 1) % 4;
          end
          win = -1; started = 0; cd = -1;
        end
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(0, 3) == 0) begin
            pend[i] = 1; waits[i] = 0;
            a_m[i] = 7'($urandom); rw_m[i] = 1'($urandom); wd_m[i] = 8'($urandom);
            bus.req_addr[i] = a_m[i]; bus.req_rw[i] = rw_m[i]; bus.req_wdata[i] = wd_m[i];
            bus.req[i] = 1'b1;
          end
        end
        bus.m_busy = ($urandom_range(0, 3) == 0);
      end
      chk("rnd_some_traffic", txm > 20, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 400000: the maximum number of cycles spent waiting for m_done (10 ms at 40 MHz).
REQ-002 Parameter SYS_FREQ, default 40000000: system clock frequency in Hz, for documentation only.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  system clock; all logic is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  4  per-requester request; held high until that requester's rsp_valid bit.
REQ-007 req_addr  in  28  four 7-bit target addresses; requester i uses bits [7i+6:7i].
REQ-008 req_rw  in  4  per-requester direction; 1 = read, 0 = write.
REQ-009 req_wdata  in  32  four 8-bit write bytes; requester i uses bits [8i+7:8i].
REQ-010 gnt  out  4  one-hot grant, or all zeros.
REQ-011 rsp_valid  out  4  one-hot, 1-cycle completion pulse.
REQ-012 rsp_rdata  out  8  read byte; valid with rsp_valid.
REQ-013 rsp_err  out  1  error flag (NACK or timeout); valid with rsp_valid.
REQ-014 m_start  out  1  1-cycle start pulse to the I2C master.
REQ-015 m_addr  out  7  latched target address.
REQ-016 m_rw  out  1  latched direction.
REQ-017 m_wdata  out  8  latched write byte.
REQ-018 m_busy  in  1  the master is in a transaction.
REQ-019 m_done  in  1  1-cycle completion pulse from the master.
REQ-020 m_ack_err  in  1  the master's NACK flag; sampled with m_done.
REQ-021 m_rdata  in  8  the master's read byte; sampled with m_done.
REQ-022 tx_count  out  16  completed transactions; wraps 0xFFFF -> 0.
REQ-023 err_count  out  8  errored transactions; saturates at 0xFF.

Function
REQ-024 The FSM SHALL have the states IDLE, ARB, ISSUE, WAIT, RESP.
REQ-025 IDLE: when any req bit is high, the FSM SHALL go to ARB on the next edge; otherwise it SHALL stay in IDLE.
REQ-026 ARB: the FSM SHALL pick the first high req bit searching from pointer ptr upward, mod 4.
REQ-027 ARB: it SHALL set gnt to the winner and latch that winner's addr, rw and wdata into m_addr, m_rw and m_wdata.
REQ-028 ARB: it SHALL then go to ISSUE.
REQ-029 ARB: if no req bit is high in ARB (the request was withdrawn), the FSM SHALL return to IDLE with gnt = 0.
REQ-030 ISSUE: while m_busy = 1, the FSM SHALL hold in ISSUE.
REQ-031 ISSUE: when m_busy = 0, it SHALL assert m_start for exactly 1 cycle, clear the timeout counter and go to WAIT.
REQ-032 WAIT: the timeout counter SHALL increment every cycle.
REQ-033 WAIT: on m_done, the FSM SHALL capture m_rdata into rsp_rdata and m_ack_err into rsp_err, then go to RESP.
REQ-034 WAIT: when the counter reaches TIMEOUT_CYC-1 without m_done, the FSM SHALL set rsp_err = 1 and rsp_rdata = 0x00, then go to RESP.
REQ-035 WAIT: if m_done and the timeout occur in the same cycle, m_done SHALL win.
REQ-036 RESP: the FSM SHALL pulse rsp_valid[winner] for 1 cycle and clear gnt.
REQ-037 RESP: it SHALL set ptr = (winner + 1) mod 4.
REQ-038 RESP: it SHALL increment tx_count, and increment err_count if rsp_err = 1.
REQ-039 RESP: it SHALL then go to IDLE.
REQ-040 gnt SHALL stay stable from ARB through WAIT.
REQ-041 A req deassert after grant SHALL NOT abort the transaction.
REQ-042 m_addr, m_rw and m_wdata SHALL stay constant from ARB until the next ARB.
REQ-043 Latency: with req rising in IDLE at edge 0 and m_busy = 0, gnt SHALL be seen after edge 2.
REQ-044 Latency: m_start SHALL be high after edge 3.
REQ-045 Latency: rsp_valid SHALL be high 2 edges after the m_done edge.
REQ-046 m_done outside WAIT SHALL be ignored.
REQ-047 At most one transaction SHALL be outstanding at any time.
REQ-048 No requester SHALL wait more than 3 other grants.

Reset
REQ-049 While rst = 0, asynchronously: the FSM SHALL be in IDLE.
REQ-050 While rst = 0: ptr = 0; gnt, rsp_valid, m_start and rsp_err = 0.
REQ-051 While rst = 0: rsp_rdata, m_addr, m_rw and m_wdata = 0; tx_count and err_count = 0; the timeout counter = 0.
REQ-052 Reset mid-transaction SHALL abandon it with no rsp_valid.

Verification
REQ-053 Scenario: req = 0001, addr 0x50, rw 0, wdata 0xA5; m_done after 10 cycles with m_ack_err = 0 -> one m_start, m_addr = 0x50, m_wdata = 0xA5, rsp_valid = 0001, rsp_err = 0, tx_count = 1.
REQ-054 Scenario: req = 1111 held, each served -> grant order 0, 1, 2, 3, 0; never a double grant.
REQ-055 Scenario: read from requester 2 with m_rdata = 0x3C, m_ack_err = 1 -> rsp_valid = 0100, rsp_rdata = 0x3C, rsp_err = 1, err_count = 1.
REQ-056 Scenario: no m_done, TIMEOUT_CYC = 50 -> rsp_valid exactly 50 cycles after the WAIT entry, rsp_err = 1, rsp_rdata = 0x00.
REQ-057 Scenario: m_busy = 1 for 20 cycles after the grant -> m_start is withheld until the cycle after m_busy falls.
REQ-058 Scenario: rst low during WAIT -> all outputs 0 immediately; a later m_done produces no rsp_valid.
